// File: rtl/register_file_2r1w.sv
// register_file_2r1w: parametrised register file with one synchronous write
// port and two independent combinational read ports. Each entry carries a
// "written since reset" flag, and wr_count tracks how many entries are valid.
// Optional same-cycle write-to-read bypass and optional hard-wired zero entry.
module register_file_2r1w #(
  parameter int                WIDTH     = 8,
  parameter int                ADDR_W    = 2,
  parameter int                BYPASS    = 1,
  parameter int                ZERO_REG  = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]  w_data,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic [WIDTH-1:0]  r0_data,
  output logic              r0_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [WIDTH-1:0]  r1_data,
  output logic              r1_valid,
  output logic [ADDR_W:0]   wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             write_ok;
  logic             r0_zero;
  logic             r1_zero;
  logic             r0_hit;
  logic             r1_hit;

  // A write only takes effect when enabled and not aimed at the zero entry.
  // Reset is handled separately: it dominates both storage and bypass.
  assign write_ok = w_en && !((ZERO_REG != 0) && (w_addr == '0));

  assign r0_zero = (ZERO_REG != 0) && (r0_addr == '0);
  assign r1_zero = (ZERO_REG != 0) && (r1_addr == '0);

  // Bypass hits: same-cycle forwarding of w_data to a matching read port.
  assign r0_hit = (BYPASS != 0) && !rst && write_ok && (w_addr == r0_addr);
  assign r1_hit = (BYPASS != 0) && !rst && write_ok && (w_addr == r1_addr);

  // Storage, valid flags and count of distinct written entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
      valid    <= '0;
      wr_count <= '0;
    end else if (write_ok) begin
      mem[w_addr]   <= w_data;
      valid[w_addr] <= 1'b1;
      // Only a first write to an entry grows the count; overwrites do not.
      if (!valid[w_addr]) begin
        wr_count <= wr_count + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  // Read port 0: zero entry first, then bypass, then stored contents.
  always_comb begin
    r0_data  = mem[r0_addr];
    r0_valid = valid[r0_addr];
    if (r0_zero) begin
      r0_data  = '0;
      r0_valid = 1'b1;
    end else if (r0_hit) begin
      r0_data  = w_data;
      r0_valid = 1'b1;
    end
  end

  // Read port 1: same selection order as port 0, fully independent.
  always_comb begin
    r1_data  = mem[r1_addr];
    r1_valid = valid[r1_addr];
    if (r1_zero) begin
      r1_data  = '0;
      r1_valid = 1'b1;
    end else if (r1_hit) begin
      r1_data  = w_data;
      r1_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w. Three instances share one stimulus bus:
// default parameters, BYPASS=0 and ZERO_REG=1. Each test starts from reset
// and checks the instance whose parameterisation it exercises.
module tb_register_file_2r1w;

  logic       clk;
  logic       rst;
  logic       w_en;
  logic [1:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] r0_addr;
  logic [1:0] r1_addr;

  logic [7:0] d_r0_data, d_r1_data;
  logic       d_r0_valid, d_r1_valid;
  logic [2:0] d_wr_count;
  logic [7:0] n_r0_data, n_r1_data;
  logic       n_r0_valid, n_r1_valid;
  logic [2:0] n_wr_count;
  logic [7:0] z_r0_data, z_r1_data;
  logic       z_r0_valid, z_r1_valid;
  logic [2:0] z_wr_count;

  int n_cmp;
  int n_err;

  logic [8:0] exp_q[$];

  register_file_2r1w u_dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r0_data(d_r0_data), .r0_valid(d_r0_valid),
    .r1_addr(r1_addr), .r1_data(d_r1_data), .r1_valid(d_r1_valid),
    .wr_count(d_wr_count)
  );

  register_file_2r1w #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r0_data(n_r0_data), .r0_valid(n_r0_valid),
    .r1_addr(r1_addr), .r1_data(n_r1_data), .r1_valid(n_r1_valid),
    .wr_count(n_wr_count)
  );

  register_file_2r1w #(.ZERO_REG(1)) u_zr (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r0_addr(r0_addr), .r0_data(z_r0_data), .r0_valid(z_r0_valid),
    .r1_addr(r1_addr), .r1_data(z_r1_data), .r1_valid(z_r1_valid),
    .wr_count(z_wr_count)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       w_en;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic [1:0] r0_addr;
    logic [1:0] r1_addr;
    logic [7:0] exp_r0;
    logic       exp_v0;
    logic [7:0] exp_r1;
    logic       exp_v1;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic en, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra0, input logic [1:0] ra1);
    w_en    = en;
    w_addr  = wa;
    w_data  = wd;
    r0_addr = ra0;
    r1_addr = ra1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0);

    //              en   wa    wd     r0    r1    exp_r0 v0  exp_r1 v1  cnt
    vecs[0]  = '{1'b1, 2'd0, 8'd10, 2'd0, 2'd1, 8'd10, 1'b1, 8'd0,  1'b0, 3'd0};
    vecs[1]  = '{1'b1, 2'd1, 8'd20, 2'd1, 2'd0, 8'd20, 1'b1, 8'd10, 1'b1, 3'd1};
    vecs[2]  = '{1'b1, 2'd2, 8'd30, 2'd2, 2'd3, 8'd30, 1'b1, 8'd0,  1'b0, 3'd2};
    vecs[3]  = '{1'b1, 2'd3, 8'd40, 2'd3, 2'd2, 8'd40, 1'b1, 8'd30, 1'b1, 3'd3};
    vecs[4]  = '{1'b0, 2'd0, 8'd0,  2'd3, 2'd0, 8'd40, 1'b1, 8'd10, 1'b1, 3'd4};
    vecs[5]  = '{1'b0, 2'd0, 8'd0,  2'd2, 2'd1, 8'd30, 1'b1, 8'd20, 1'b1, 3'd4};
    vecs[6]  = '{1'b0, 2'd0, 8'd0,  2'd1, 2'd2, 8'd20, 1'b1, 8'd30, 1'b1, 3'd4};
    vecs[7]  = '{1'b0, 2'd0, 8'd0,  2'd0, 2'd3, 8'd10, 1'b1, 8'd40, 1'b1, 3'd4};
    vecs[8]  = '{1'b1, 2'd2, 8'h55, 2'd2, 2'd2, 8'h55, 1'b1, 8'h55, 1'b1, 3'd4};
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'h55, 1'b1, 8'h55, 1'b1, 3'd4};
    vecs[10] = '{1'b1, 2'd1, 8'h66, 2'd1, 2'd2, 8'h66, 1'b1, 8'h55, 1'b1, 3'd4};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 8'h66, 1'b1, 8'd10, 1'b1, 3'd4};

    // Test 1: reset state on every address (default instance)
    do_reset();
    for (int a = 0; a < 4; a++) exp_q.push_back({1'b0, 8'h00});
    for (int a = 0; a < 4; a++) begin
      logic [8:0] e;
      drive(1'b0, 2'd0, 8'h00, 2'(a), 2'(a));
      to_sample();
      e = exp_q.pop_front();
      check($sformatf("rst_r0_a%0d", a), {23'd0, d_r0_valid, d_r0_data}, {23'd0, e});
      check($sformatf("rst_r1_a%0d", a), {23'd0, d_r1_valid, d_r1_data}, {23'd0, e});
    end
    check("rst_cnt", {29'd0, d_wr_count}, 32'd0);

    // Tests 2-3: write/bypass/sweep/overwrite vectors (default instance)
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].w_en, vecs[i].w_addr, vecs[i].w_data, vecs[i].r0_addr, vecs[i].r1_addr);
      to_sample();
      check($sformatf("v%0d_r0", i),  {24'd0, d_r0_data},  {24'd0, vecs[i].exp_r0});
      check($sformatf("v%0d_v0", i),  {31'd0, d_r0_valid}, {31'd0, vecs[i].exp_v0});
      check($sformatf("v%0d_r1", i),  {24'd0, d_r1_data},  {24'd0, vecs[i].exp_r1});
      check($sformatf("v%0d_v1", i),  {31'd0, d_r1_valid}, {31'd0, vecs[i].exp_v1});
      check($sformatf("v%0d_cnt", i), {29'd0, d_wr_count}, {29'd0, vecs[i].exp_cnt});
      tick();
    end

    // Test 4: no-bypass instance shows old value until the edge
    do_reset();
    drive(1'b1, 2'd1, 8'hAA, 2'd1, 2'd1);
    to_sample();
    check("nb_pre_r0",    {24'd0, n_r0_data},  32'h00);
    check("nb_pre_v0",    {31'd0, n_r0_valid}, 32'd0);
    check("byp_pre_r0",   {24'd0, d_r0_data},  32'hAA);
    tick();
    drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd1);
    to_sample();
    check("nb_post_r0",   {24'd0, n_r0_data},  32'hAA);
    check("nb_post_v0",   {31'd0, n_r0_valid}, 32'd1);
    check("nb_post_cnt",  {29'd0, n_wr_count}, 32'd1);
    tick();

    // Test 5: zero entry instance
    do_reset();
    drive(1'b1, 2'd0, 8'h7F, 2'd0, 2'd3);
    to_sample();
    check("zr_w0_r0",     {24'd0, z_r0_data},  32'h00);
    check("zr_w0_v0",     {31'd0, z_r0_valid}, 32'd1);
    tick();
    drive(1'b1, 2'd3, 8'h11, 2'd0, 2'd3);
    to_sample();
    check("zr_w3_byp",    {24'd0, z_r1_data},  32'h11);
    check("zr_w3_cnt",    {29'd0, z_wr_count}, 32'd0);
    tick();
    drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd3);
    to_sample();
    check("zr_r0",        {24'd0, z_r0_data},  32'h00);
    check("zr_v0",        {31'd0, z_r0_valid}, 32'd1);
    check("zr_r3",        {24'd0, z_r1_data},  32'h11);
    check("zr_v3",        {31'd0, z_r1_valid}, 32'd1);
    check("zr_cnt",       {29'd0, z_wr_count}, 32'd1);
    tick();

    // Test 6: reset coinciding with a write (default instance)
    drive(1'b1, 2'd2, 8'h33, 2'd2, 2'd2);
    tick();
    rst = 1'b1;
    drive(1'b1, 2'd2, 8'h99, 2'd2, 2'd2);
    to_sample();
    check("rw_pre_r0",    {24'd0, d_r0_data},  32'h33);
    check("rw_pre_r1",    {24'd0, d_r1_data},  32'h33);
    check("rw_pre_cnt",   {29'd0, d_wr_count}, 32'd3);
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd0);
    to_sample();
    check("rw_post_r0",   {24'd0, d_r0_data},  32'h00);
    check("rw_post_v0",   {31'd0, d_r0_valid}, 32'd0);
    check("rw_post_v1",   {31'd0, d_r1_valid}, 32'd0);
    check("rw_post_cnt",  {29'd0, d_wr_count}, 32'd0);
    tick();

    // X on w_data with w_en low must leave state untouched
    w_data = 8'hxx;
    tick();
    w_data = 8'h00;
    to_sample();
    check("x_r0",         {24'd0, d_r0_data},  32'h00);
    check("x_v0",         {31'd0, d_r0_valid}, 32'd0);
    check("x_cnt",        {29'd0, d_wr_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
